// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: next-PC select
// encoding, parameter defaults and the return-stack pointer width helper.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_BRANCH = 3'd1,
        SEL_JUMP   = 3'd2,
        SEL_CALL   = 3'd3,
        SEL_RET    = 3'd4,
        SEL_HOLD   = 3'd5
    } pc_sel_e;

    localparam int DEF_RESET_VEC = 0;
    localparam int DEF_INC       = 1;

    function automatic int ras_pw(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push on a full stack overwrites the oldest
// entry; a pop on an empty stack only raises the underflow pulse.
module ras_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int PW    = ras_pw(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [PW:0]      count,
    output logic             ovf,
    output logic             unf
);

    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp;
    logic [PW-1:0]    sp_prev;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = !hold && pop;
    assign do_push = !hold && push && !pop;
    assign sp_prev = sp - PW'(1);
    assign top     = mem[sp_prev];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ovf <= do_push && full;
            unf <= do_pop && empty;
            if (do_pop && !empty) begin
                sp    <= sp_prev;
                count <= count - (PW+1)'(1);
            end else if (do_push) begin
                sp <= sp + PW'(1);
                if (!full)
                    count <= count + (PW+1)'(1);
            end
        end
    end

    // Entries are deliberately left out of reset; only sp/count define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[sp] <= push_data;
    end

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with branch/jump/call/return and a circular
// return-address stack. Priority: stall > ret > call > jump > branch > sequential.
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int                 WIDTH     = 32,
    parameter int                 INC       = DEF_INC,
    parameter logic [WIDTH-1:0]   RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter int                 RAS_DEPTH = 4,
    parameter int                 RAS_PW    = ras_pw(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [WIDTH-1:0]  pc_in,
    output logic [WIDTH-1:0]  pc,
    output logic [RAS_PW:0]   ras_count,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf
);

    localparam logic [WIDTH-1:0]  INC_W   = WIDTH'(INC);
    localparam logic [RAS_PW:0]   DEPTH_C = (RAS_PW+1)'(RAS_DEPTH);

    pc_sel_e          sel;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] ras_top;

    always_comb begin
        sel = SEL_SEQ;
        if (stall)       sel = SEL_HOLD;
        else if (ret)    sel = SEL_RET;
        else if (call)   sel = SEL_CALL;
        else if (jump)   sel = SEL_JUMP;
        else if (branch) sel = SEL_BRANCH;
    end

    assign pc_inc = pc + INC_W;

    // Branch offset is two's complement; modulo-2^WIDTH addition handles the sign.
    always_comb begin
        pc_next = pc_inc;
        unique case (sel)
            SEL_HOLD:   pc_next = pc;
            SEL_RET:    pc_next = ras_empty ? pc_inc : ras_top;
            SEL_CALL:   pc_next = pc_in;
            SEL_JUMP:   pc_next = pc_in;
            SEL_BRANCH: pc_next = pc_inc + pc_in;
            default:    pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc <= RESET_VEC;
        else
            pc <= pc_next;
    end

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH),
        .PW    (RAS_PW)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .hold      (sel == SEL_HOLD),
        .push      (sel == SEL_CALL),
        .pop       (sel == SEL_RET),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_count),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == DEPTH_C);

endmodule
